// File: rtl/phoenix.sv
// phoenix: multi-cycle RV32I/M core, FETCH -> EXECUTE -> (MEMORY) -> FETCH.
// Define PHOENIX_CSR_COUNTERS_EN for read-only mcycle/minstret CSRs.
module phoenix #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter bit          M_EXTENSION   = 1'b1,
  parameter bit          E_EXTENSION   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instruction_memory_interface_enable,
  output logic        instruction_memory_interface_state,
  output logic [31:0] instruction_memory_interface_address,
  output logic [3:0]  instruction_memory_interface_frame_mask,
  input  logic [31:0] instruction_memory_interface_data,
  output logic        data_memory_interface_enable,
  output logic        data_memory_interface_state,
  output logic [31:0] data_memory_interface_address,
  output logic [3:0]  data_memory_interface_frame_mask,
  inout  wire  [31:0] data_memory_interface_data
);

  typedef enum logic [1:0] {
    FETCH, EXECUTE, MEMORY, HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, ir;
  logic [31:0] rf [32];
  logic        rd_we, retire;
  logic [31:0] rd_val;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1_i, rs2_i, rd_i;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  // RV32E only has 16 registers; bit 4 of each index is dropped.
  assign rs1_i = E_EXTENSION ? {1'b0, ir[18:15]} : ir[19:15];
  assign rs2_i = E_EXTENSION ? {1'b0, ir[23:20]} : ir[24:20];
  assign rd_i  = E_EXTENSION ? {1'b0, ir[10:7]}  : ir[11:7];

  logic [31:0] a, b, pc4;
  assign a   = rf[rs1_i];
  assign b   = rf[rs2_i];
  assign pc4 = pc + 32'd4;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_opi, is_op, is_sys;
  logic is_ebreak, is_csr, is_mul;

  assign is_lui    = opc == 7'b0110111;
  assign is_auipc  = opc == 7'b0010111;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_br     = opc == 7'b1100011;
  assign is_ld     = opc == 7'b0000011;
  assign is_st     = opc == 7'b0100011;
  assign is_opi    = opc == 7'b0010011;
  assign is_op     = opc == 7'b0110011;
  assign is_sys    = opc == 7'b1110011;
  assign is_ebreak = ir == 32'h0010_0073;
  assign is_csr    = is_sys && f3 != 3'b000;
  assign is_mul    = is_op && f7 == 7'b0000001;

  logic [31:0] opb, alu, sra_v;
  logic [4:0]  shamt;
  logic        lt, ltu;

  assign opb   = is_op ? b : imm_i;
  assign shamt = opb[4:0];
  assign lt    = $signed(a) < $signed(opb);
  assign ltu   = a < opb;
  assign sra_v = $signed(a) >>> shamt;

  always_comb begin
    alu = '0;
    case (f3)
      3'b000: alu = (is_op && ir[30]) ? a - opb : a + opb;
      3'b001: alu = a << shamt;
      3'b010: alu = {31'b0, lt};
      3'b011: alu = {31'b0, ltu};
      3'b100: alu = a ^ opb;
      3'b101: alu = ir[30] ? sra_v : a >> shamt;
      3'b110: alu = a | opb;
      3'b111: alu = a & opb;
      default: alu = '0;
    endcase
  end

  logic [63:0] p_ss, p_su, p_uu;
  logic [31:0] q_s, r_s, q_u, r_u, mres;
  logic        dz, ovf;
  logic        mul_unused;

  assign p_ss = $signed({{32{a[31]}}, a})
              * $signed({{32{b[31]}}, b});
  assign p_su = $signed({{32{a[31]}}, a})
              * $signed({32'b0, b});
  assign p_uu = {32'b0, a} * {32'b0, b};
  assign mul_unused = ^{p_ss[31:0], p_su[31:0]};

  assign dz  = b == 32'd0;
  assign ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  // Divider inputs are steered away from /0 and overflow cases.
  assign q_s = (dz || ovf) ? 32'd0 : $signed(a) / $signed(b);
  assign r_s = (dz || ovf) ? 32'd0 : $signed(a) % $signed(b);
  assign q_u = dz ? 32'd0 : a / b;
  assign r_u = dz ? 32'd0 : a % b;

  always_comb begin
    mres = '0;
    case (f3)
      3'b000: mres = p_uu[31:0];
      3'b001: mres = p_ss[63:32];
      3'b010: mres = p_su[63:32];
      3'b011: mres = p_uu[63:32];
      3'b100: mres = dz ? '1 : (ovf ? a : q_s);
      3'b101: mres = dz ? '1 : q_u;
      3'b110: mres = dz ? a : (ovf ? 32'd0 : r_s);
      3'b111: mres = dz ? a : r_u;
      default: mres = '0;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = a == b;
      3'b001: taken = a != b;
      3'b100: taken = $signed(a) < $signed(b);
      3'b101: taken = $signed(a) >= $signed(b);
      3'b110: taken = a < b;
      3'b111: taken = a >= b;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] daddr, rdata, lsh, ld_val, wdata;
  logic [3:0]  dmask;
  logic        drive;

  assign daddr = a + (is_st ? imm_s : imm_i);
  assign rdata = data_memory_interface_data;
  assign lsh   = rdata >> {daddr[1:0], 3'b000};

  always_comb begin
    ld_val = rdata;
    case (f3[1:0])
      2'b00: ld_val = f3[2] ? {24'b0, lsh[7:0]}
                            : {{24{lsh[7]}}, lsh[7:0]};
      2'b01: ld_val = f3[2] ? {16'b0, lsh[15:0]}
                            : {{16{lsh[15]}}, lsh[15:0]};
      default: ld_val = rdata;
    endcase
  end

  // Mask bit 3 is the lowest byte lane, so masks shift right.
  always_comb begin
    dmask = 4'b1111;
    wdata = b;
    case (f3[1:0])
      2'b00: begin
        dmask = 4'b1000 >> daddr[1:0];
        wdata = {4{b[7:0]}};
      end
      2'b01: begin
        dmask = daddr[1] ? 4'b0011 : 4'b1100;
        wdata = {2{b[15:0]}};
      end
      default: begin
        dmask = 4'b1111;
        wdata = b;
      end
    endcase
  end

  logic [31:0] csr_val;

`ifdef PHOENIX_CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (retire) minstret <= minstret + 64'd1;
    end
  end

  always_comb begin
    csr_val = '0;
    case (ir[31:20])
      12'hB00: csr_val = mcycle[31:0];
      12'hB02: csr_val = minstret[31:0];
      12'hB80: csr_val = mcycle[63:32];
      12'hB82: csr_val = minstret[63:32];
      default: csr_val = '0;
    endcase
  end
`else
  logic retire_unused;
  assign retire_unused = retire;
  assign csr_val = '0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    rd_we     = 1'b0;
    rd_val    = '0;
    retire    = 1'b0;
    unique case (state)
      FETCH: state_nxt = EXECUTE;
      EXECUTE: begin
        state_nxt = FETCH;
        pc_nxt    = pc4;
        retire    = 1'b1;
        unique case (1'b1)
          is_ebreak: begin
            state_nxt = HALT;
            pc_nxt    = pc;
            retire    = 1'b0;
          end
          is_ld, is_st: begin
            state_nxt = MEMORY;
            pc_nxt    = pc;
            retire    = 1'b0;
          end
          is_lui: begin
            rd_we  = 1'b1;
            rd_val = imm_u;
          end
          is_auipc: begin
            rd_we  = 1'b1;
            rd_val = pc + imm_u;
          end
          is_jal: begin
            rd_we  = 1'b1;
            rd_val = pc4;
            pc_nxt = pc + imm_j;
          end
          is_jalr: begin
            rd_we  = 1'b1;
            rd_val = pc4;
            pc_nxt = (a + imm_i) & ~32'd1;
          end
          is_br: pc_nxt = taken ? pc + imm_b : pc4;
          is_opi: begin
            rd_we  = 1'b1;
            rd_val = alu;
          end
          is_op: begin
            rd_we  = !is_mul || M_EXTENSION;
            rd_val = is_mul ? mres : alu;
          end
          is_csr: begin
            rd_we  = 1'b1;
            rd_val = csr_val;
          end
          default: ;
        endcase
      end
      MEMORY: begin
        state_nxt = FETCH;
        pc_nxt    = pc4;
        retire    = 1'b1;
        rd_we     = is_ld;
        rd_val    = ld_val;
      end
      HALT: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_ADDRESS;
      ir    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH)
        ir <= instruction_memory_interface_data;
      if (rd_we && rd_i != 5'd0)
        rf[rd_i] <= rd_val;
    end
  end

  assign drive = reset && state == MEMORY && is_st;

  assign instruction_memory_interface_enable =
    reset && state == FETCH;
  assign instruction_memory_interface_state      = 1'b0;
  assign instruction_memory_interface_address    = pc;
  assign instruction_memory_interface_frame_mask = 4'b1111;

  assign data_memory_interface_enable = reset && state == MEMORY;
  assign data_memory_interface_state  = is_st;
  assign data_memory_interface_address    = daddr;
  assign data_memory_interface_frame_mask = dmask;
  assign data_memory_interface_data = drive ? wdata : 'z;

endmodule

// File: tb/tb_phoenix.sv
// tb_phoenix: directed program run on phoenix with flat
// instruction/data memories and immediate-assertion checks.
module tb_phoenix;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ie, ist, de, dst;
  logic [31:0] ia, idata, da;
  logic [3:0]  im, dm;
  wire  [31:0] dbus;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] wmerge;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] MD  = 7'b0000001;

  always #5 clk = ~clk;

  phoenix dut (
    .clk                                     (clk),
    .reset                                   (reset),
    .instruction_memory_interface_enable     (ie),
    .instruction_memory_interface_state      (ist),
    .instruction_memory_interface_address    (ia),
    .instruction_memory_interface_frame_mask (im),
    .instruction_memory_interface_data       (idata),
    .data_memory_interface_enable            (de),
    .data_memory_interface_state             (dst),
    .data_memory_interface_address           (da),
    .data_memory_interface_frame_mask        (dm),
    .data_memory_interface_data              (dbus)
  );

  assign idata = imem[ia[9:2]];
  assign dbus  = (de && !dst) ? dmem[da[7:2]] : 32'bz;

  always_comb begin
    wmerge = dmem[da[7:2]];
    for (int k = 0; k < 4; k++)
      if (dm[3-k]) wmerge[8*k +: 8] = dbus[8*k +: 8];
  end

  always @(posedge clk)
    if (de && dst) dmem[da[7:2]] <= wmerge;

  function automatic logic [31:0] enc_i(
    logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
    logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(
    logic [19:0] imm, logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_j(
    logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(
    logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic next_fetch(input logic [31:0] exp,
                            input string tag,
                            output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ie && n < 20);
    chk(tag, ie ? ia : 32'hDEAD_BEEF, exp);
  endtask

  task automatic run_to_fetch(input logic [31:0] exp,
                              input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(ie && ia == exp) && n < 300);
    chk(tag, ie ? ia : 32'hDEAD_BEEF, exp);
  endtask

  task automatic wait_dmem(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!de && n < 20);
    chk(tag, {31'b0, de}, 32'd1);
  endtask

  initial begin
    int n;
    int bad;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    imem[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    imem[1]  = enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, OPI);
    imem[2]  = enc_i(12'd1, 5'd4, 3'd0, 5'd4, OPI);
    imem[3]  = enc_i(12'hFFF, 5'd4, 3'd0, 5'd5, OPI);
    imem[4]  = enc_b(13'h1FF8, 5'd0, 5'd5, 3'd0);
    imem[5]  = enc_u(20'h10000, 5'd6);
    imem[6]  = enc_i(12'h0AB, 5'd0, 3'd0, 5'd7, OPI);
    imem[7]  = enc_s(12'd1, 5'd7, 5'd6, 3'd0);
    imem[8]  = enc_j(21'd12, 5'd1);
    imem[9]  = enc_i(12'd1, 5'd0, 3'd0, 5'd9, OPI);
    imem[10] = enc_i(12'd2, 5'd0, 3'd0, 5'd9, OPI);
    imem[11] = enc_i(12'd1, 5'd6, 3'd0, 5'd8, LD);
    imem[12] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, OPI);
    imem[13] = enc_r(MD, 5'd0, 5'd1, 3'd4, 5'd3);
    imem[14] = enc_r(MD, 5'd0, 5'd1, 3'd6, 5'd10);
    imem[15] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd11, OPI);
    imem[16] = enc_i(12'd2, 5'd0, 3'd0, 5'd12, OPI);
    imem[17] = enc_r(MD, 5'd12, 5'd11, 3'd0, 5'd13);
    imem[18] = enc_i(12'd1, 5'd6, 3'd4, 5'd14, LD);
    imem[19] = enc_s(12'd2, 5'd2, 5'd6, 3'd1);
    imem[20] = enc_i(12'd0, 5'd6, 3'd2, 5'd15, LD);
    imem[21] = enc_i(12'd3, 5'd0, 3'd0, 5'd16, OPI);
    imem[22] = enc_i(12'hB00, 5'd0, 3'd2, 5'd16, SYS);
    imem[23] = enc_u(20'h80000, 5'd18);
    imem[24] = enc_r(MD, 5'd11, 5'd18, 3'd4, 5'd17);
    imem[25] = enc_r(MD, 5'd11, 5'd18, 3'd6, 5'd19);
    imem[26] = 32'h0010_0073;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_en", {31'b0, ie}, 32'd0);
    chk("rst_dmem_en", {31'b0, de}, 32'd0);
    chk("rst_pc", dut.pc, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("first_fetch_en", {31'b0, ie}, 32'd1);
    chk("first_fetch_addr", ia, 32'h0);
    chk("first_fetch_state", {31'b0, ist}, 32'd0);
    chk("first_fetch_mask", {28'b0, im}, 32'hF);
    next_fetch(32'h04, "fetch_4", n);
    chk("fetch_4_cycles", n, 32'd2);

    next_fetch(32'h08, "fetch_8", n);
    next_fetch(32'h0C, "fetch_c", n);
    next_fetch(32'h10, "fetch_10", n);
    next_fetch(32'h08, "beq_taken", n);
    next_fetch(32'h0C, "fetch_c_2", n);
    next_fetch(32'h10, "fetch_10_2", n);
    next_fetch(32'h14, "beq_not_taken", n);
    chk("addi_neg", dut.rf[2], 32'hFFFF_FFFE);
    chk("loop_count", dut.rf[4], 32'd2);

    next_fetch(32'h18, "fetch_18", n);
    next_fetch(32'h1C, "fetch_1c", n);
    wait_dmem("sb_en", n);
    chk("sb_cycles", n, 32'd2);
    chk("sb_addr", da, 32'h1000_0001);
    chk("sb_mask", {28'b0, dm}, 32'h4);
    chk("sb_state", {31'b0, dst}, 32'd1);
    chk("sb_lane", {24'b0, dbus[15:8]}, 32'hAB);
    next_fetch(32'h20, "fetch_20", n);
    chk("store_cycles", n, 32'd1);
    next_fetch(32'h2C, "jal_target", n);
    chk("jal_link", dut.rf[1], 32'h24);

    wait_dmem("lb_en", n);
    chk("lb_state", {31'b0, dst}, 32'd0);
    chk("lb_addr", da, 32'h1000_0001);
    next_fetch(32'h30, "fetch_30", n);
    chk("lb_val", dut.rf[8], 32'hFFFF_FFAB);

    wait_dmem("lbu_en", n);
    wait_dmem("sh_en", n);
    chk("sh_addr", da, 32'h1000_0002);
    chk("sh_mask", {28'b0, dm}, 32'h3);
    chk("sh_state", {31'b0, dst}, 32'd1);
    chk("sh_data", dbus, 32'hFFFE_FFFE);
    wait_dmem("lw_en", n);
    chk("lw_mask", {28'b0, dm}, 32'hF);

    run_to_fetch(32'h68, "fetch_ebreak");
    step();
    step();
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      if (ie || de) bad++;
      step();
    end
    chk("halt_enables", bad, 32'd0);
    chk("halt_pc", dut.pc, 32'h68);

    chk("div_by_zero", dut.rf[3], 32'hFFFF_FFFF);
    chk("rem_by_zero", dut.rf[10], 32'd7);
    chk("mul_lo", dut.rf[13], 32'hFFFF_FFFE);
    chk("lbu_val", dut.rf[14], 32'hAB);
    chk("lw_val", dut.rf[15], 32'hFFFE_AB00);
    chk("csr_zero", dut.rf[16], 32'd0);
    chk("div_ovf", dut.rf[17], 32'h8000_0000);
    chk("rem_ovf", dut.rf[19], 32'd0);
    chk("jal_skip", dut.rf[9], 32'd0);
    chk("x1_final", dut.rf[1], 32'd7);

    reset = 1'b0;
    #1;
    chk("rst2_imem_en", {31'b0, ie}, 32'd0);
    chk("rst2_regs", dut.rf[3], 32'd0);
    chk("rst2_pc", dut.pc, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("restart_en", {31'b0, ie}, 32'd1);
    chk("restart_addr", ia, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
